bp_be_fpu_long_sched: RTL

Arbiter and sequencer sharing one iterative long-latency FP unit (double-precision divide/sqrt) among `num_req_p` requesters in the backend calculator. It grants round-robin and launches at most one operation at a time into the unit over a valid/ready handshake. It captures the unit's valid/yumi result and returns it to the originating requester together with that requester's tag. A pipeline flush cancels the in-flight operation and silently drains any result still owed by the unit.

---
 rtl/bp_be_fpu_long_sched.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/bp_be_fpu_long_sched.sv
// Round-robin scheduler that shares one iterative long-latency FP unit (div/sqrt)
// among several requesters, returning each result with its requester id and tag.
module bp_be_fpu_long_sched #(
   parameter int unsigned num_req_p    = 2,
   parameter int unsigned cmd_width_p  = 138,
   parameter int unsigned data_width_p = 64,
   parameter int unsigned tag_width_p  = 5,
   localparam int unsigned id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
   input  logic                               clk_i,
   input  logic                               reset_n_i,
   input  logic [num_req_p-1:0]               req_v_i,
   output logic [num_req_p-1:0]               req_ready_o,
   input  logic [num_req_p*cmd_width_p-1:0]   req_cmd_i,
   input  logic [num_req_p*tag_width_p-1:0]   req_tag_i,
   input  logic                               flush_i,
   output logic                               unit_v_o,
   output logic [cmd_width_p-1:0]             unit_cmd_o,
   input  logic                               unit_ready_i,
   input  logic                               unit_v_i,
   input  logic [data_width_p+5-1:0]          unit_data_i,
   output logic                               unit_yumi_o,
   output logic                               resp_v_o,
   output logic [id_width_lp-1:0]             resp_id_o,
   output logic [tag_width_p-1:0]             resp_tag_o,
   output logic [data_width_p-1:0]            resp_data_o,
   output logic [4:0]                         resp_fflags_o,
   input  logic                               resp_yumi_i,
   output logic                               busy_o
);

   localparam int unsigned fflags_width_lp = 5;

   typedef enum logic [2:0] {
      e_idle,
      e_issue,
      e_wait,
      e_drain,
      e_resp
   } state_e;

   state_e                         state_r, state_n;
   logic [id_width_lp-1:0]         last_grant_r;
   logic [id_width_lp-1:0]         grant_id;
   logic [id_width_lp-1:0]         cand_id;
   logic                           grant_found;
   logic                           grant_v;
   logic                           capture_v;
   logic [cmd_width_p-1:0]         cmd_r;
   logic [tag_width_p-1:0]         tag_r;
   logic [id_width_lp-1:0]         id_r;
   logic [data_width_p-1:0]        data_r;
   logic [fflags_width_lp-1:0]     fflags_r;

   // Round-robin pick: search starts one past the last granted requester
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      cand_id     = '0;
      for (int unsigned k = 1; k <= num_req_p; k++) begin
         cand_id = id_width_lp'((32'(last_grant_r) + k) % num_req_p);
         if (!grant_found && req_v_i[cand_id]) begin
            grant_found = 1'b1;
            grant_id    = cand_id;
         end
      end
   end

   always_comb begin
      state_n     = state_r;
      req_ready_o = '0;
      unit_yumi_o = 1'b0;
      grant_v     = 1'b0;
      capture_v   = 1'b0;
      case (state_r)
         e_idle: begin
            if (grant_found && !flush_i) begin
               req_ready_o[grant_id] = 1'b1;
               grant_v               = 1'b1;
               state_n               = e_issue;
            end
         end
         e_issue: begin
            if (unit_ready_i) begin
               state_n = flush_i ? e_drain : e_wait;
            end else if (flush_i) begin
               state_n = e_idle;
            end
         end
         e_wait: begin
            unit_yumi_o = unit_v_i;
            if (unit_v_i) begin
               capture_v = !flush_i;
               state_n   = flush_i ? e_idle : e_resp;
            end else if (flush_i) begin
               state_n = e_drain;
            end
         end
         e_drain: begin
            // A result is still owed by the unit; swallow it regardless of flush
            unit_yumi_o = unit_v_i;
            if (unit_v_i) begin
               state_n = e_idle;
            end
         end
         e_resp: begin
            if (flush_i || resp_yumi_i) begin
               state_n = e_idle;
            end
         end
         default: state_n = e_idle;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r <= e_idle;
      end else begin
         state_r <= state_n;
      end
   end

   // Command, tag and originating id latched at the grant handshake
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         last_grant_r <= id_width_lp'(num_req_p - 1);
         cmd_r        <= '0;
         tag_r        <= '0;
         id_r         <= '0;
      end else if (grant_v) begin
         last_grant_r <= grant_id;
         cmd_r        <= req_cmd_i[32'(grant_id)*cmd_width_p +: cmd_width_p];
         tag_r        <= req_tag_i[32'(grant_id)*tag_width_p +: tag_width_p];
         id_r         <= grant_id;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         data_r   <= '0;
         fflags_r <= '0;
      end else if (capture_v) begin
         data_r   <= unit_data_i[fflags_width_lp +: data_width_p];
         fflags_r <= unit_data_i[fflags_width_lp-1:0];
      end
   end

   assign unit_v_o      = (state_r == e_issue);
   assign unit_cmd_o    = cmd_r;
   assign resp_v_o      = (state_r == e_resp);
   assign resp_id_o     = id_r;
   assign resp_tag_o    = tag_r;
   assign resp_data_o   = data_r;
   assign resp_fflags_o = fflags_r;
   assign busy_o        = (state_r != e_idle);

endmodule
